// File: rtl/game_state_manager_pkg.sv
// Shared encodings for the game sequencer and the sprite stages that decode its state bus.
package game_state_manager_pkg;

  typedef enum logic [1:0] {
    ST_TITLE = 2'b00,
    ST_DODGE = 2'b01,
    ST_MENU  = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CUR_FIGHT = 2'd0,
    CUR_ACT   = 2'd1,
    CUR_ITEM  = 2'd2,
    CUR_MERCY = 2'd3
  } cursor_t;

  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_Z     = 8'h1A;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_BREAK = 8'hF0;

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

endpackage

// File: rtl/game_state_manager_if.sv
// Keyboard/frame inputs and game-phase outputs shared between the sequencer and its neighbours.
interface game_state_manager_if #(
  parameter int W_TIMER = 10
);
  logic [15:0]        keycode;
  logic               frame_tick;
  logic [1:0]         hp;
  logic [1:0]         state;
  logic [1:0]         cursor;
  logic [7:0]         enemy_hp;
  logic               win;
  logic [W_TIMER-1:0] frames_left;
  logic               phase_start;

  modport master (
    output keycode, frame_tick, hp,
    input  state, cursor, enemy_hp, win, frames_left, phase_start
  );

  modport slave (
    input  keycode, frame_tick, hp,
    output state, cursor, enemy_hp, win, frames_left, phase_start
  );
endinterface

// File: rtl/game_state_manager_make_detect.sv
// PS/2 make-event detector: flags a new key press whenever the keycode word changes
// and neither byte is a break prefix.
module ps2_make_detect
  import game_state_manager_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] keycode,
  output logic        make,
  output logic [7:0]  code
);

  logic [15:0] keycode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) keycode_q <= 16'h0000;
    else        keycode_q <= keycode;
  end

  // A repeated press still shows up because the word passes through F0xx in between.
  assign make = (keycode != keycode_q) &&
                (keycode[15:8] != KEY_BREAK) &&
                (keycode[7:0]  != KEY_BREAK);
  assign code = keycode[7:0];

endmodule

// File: rtl/game_state_manager.sv
// Game phase sequencer: title / battle menu / dodge countdown / game over,
// with enemy HP bookkeeping and a phase-start strobe for the bullet patterns.
module game_state_manager
  import game_state_manager_pkg::*;
#(
  parameter int DODGE_FRAMES = 300,
  parameter int W_TIMER      = 10,
  parameter int ENEMY_HP_MAX = 100,
  parameter int DAMAGE       = 20,
  parameter int MERCY_THRESH = 30
) (
  input  logic clk,
  input  logic rst_n,
  game_state_manager_if.slave bus
);

  state_t             state_q, state_d;
  cursor_t            cursor_q, cursor_d;
  logic [7:0]         ehp_q, ehp_d;
  logic               win_q, win_d;
  logic [W_TIMER-1:0] frames_q, frames_d;
  logic               ps_q, ps_d;

  logic       make;
  logic [7:0] code;
  logic       enter, confirm;
  logic [7:0] fight_hp;
  logic       mercy_ok;

  ps2_make_detect u_make (
    .clk     (clk),
    .rst_n   (rst_n),
    .keycode (bus.keycode),
    .make    (make),
    .code    (code)
  );

  assign enter    = make && (code == KEY_ENTER);
  assign confirm  = make && ((code == KEY_Z) || (code == KEY_ENTER));
  assign fight_hp = sat_sub(ehp_q, 8'(DAMAGE));
  assign mercy_ok = (ehp_q <= 8'(MERCY_THRESH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_TITLE;
      cursor_q <= CUR_FIGHT;
      ehp_q    <= 8'(ENEMY_HP_MAX);
      win_q    <= 1'b0;
      frames_q <= '0;
      ps_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      ehp_q    <= ehp_d;
      win_q    <= win_d;
      frames_q <= frames_d;
      ps_q     <= ps_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TITLE: if (enter) state_d = ST_MENU;
      ST_MENU: begin
        if (confirm) begin
          case (cursor_q)
            CUR_FIGHT: state_d = (fight_hp == 8'd0) ? ST_OVER : ST_DODGE;
            CUR_MERCY: state_d = mercy_ok ? ST_OVER : ST_DODGE;
            default:   state_d = ST_DODGE;
          endcase
        end
      end
      // Player death outranks the frame timer.
      ST_DODGE: begin
        if (bus.hp == 2'd0)                             state_d = ST_OVER;
        else if (bus.frame_tick && frames_q == '0)      state_d = ST_MENU;
      end
      ST_OVER:  if (enter) state_d = ST_TITLE;
      default:  state_d = ST_TITLE;
    endcase
  end

  always_comb begin
    cursor_d = cursor_q;
    ehp_d    = ehp_q;
    win_d    = win_q;
    frames_d = frames_q;
    ps_d     = 1'b0;
    case (state_q)
      ST_TITLE: begin
        if (enter) begin
          ehp_d    = 8'(ENEMY_HP_MAX);
          cursor_d = CUR_FIGHT;
          win_d    = 1'b0;
        end
      end
      ST_MENU: begin
        if (make && code == KEY_LEFT)  cursor_d = cursor_t'(cursor_q - 2'd1);
        if (make && code == KEY_RIGHT) cursor_d = cursor_t'(cursor_q + 2'd1);
        if (confirm && cursor_q == CUR_FIGHT) ehp_d = fight_hp;
        if (state_d == ST_OVER) win_d = 1'b1;
      end
      ST_DODGE: begin
        if (bus.hp == 2'd0)                          win_d    = 1'b0;
        else if (bus.frame_tick && frames_q != '0)   frames_d = frames_q - W_TIMER'(1);
      end
      default: ;
    endcase
    if (state_d == ST_DODGE && state_q != ST_DODGE) begin
      frames_d = W_TIMER'(DODGE_FRAMES);
      ps_d     = 1'b1;
    end
  end

  assign bus.state       = state_q;
  assign bus.cursor      = cursor_q;
  assign bus.enemy_hp    = ehp_q;
  assign bus.win         = win_q;
  assign bus.frames_left = frames_q;
  assign bus.phase_start = ps_q;

endmodule

// File: doc/game_state_manager.md
Name: game_state_manager

Overview:
- Top-level game sequencer; sits upstream of the border, player and bullet sprite stages and drives their shared 2-bit `state` bus.
- Consumes the PS/2 `keycode` word from the keyboard block, the per-frame tick and the player `hp`.
- Produces the game phase, the battle-menu cursor, enemy HP, the dodge-phase frame countdown, and a phase-start strobe that restarts bullet patterns.

Parameters:
- DODGE_FRAMES, 300, frames spent in a dodge phase (5 s at 60 Hz); must fit in W_TIMER bits.
- W_TIMER, 10, width of the frame countdown.
- ENEMY_HP_MAX, 100, enemy HP loaded on new game; 8-bit.
- DAMAGE, 20, HP removed by a FIGHT confirm.
- MERCY_THRESH, 30, MERCY succeeds when enemy_hp <= this value.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- keycode  in  16  {previous byte, latest byte} from the PS/2 receiver
- frame_tick  in  1  one-clk pulse per frame, at the start of vertical blank
- hp  in  2  player HP from the player sprite; 0 means dead
- state  out  2  00 TITLE, 01 DODGE, 10 MENU, 11 OVER
- cursor  out  2  menu selection: 0 FIGHT, 1 ACT, 2 ITEM, 3 MERCY
- enemy_hp  out  8  remaining enemy HP
- win  out  1  set when the game ended by victory; valid in OVER
- frames_left  out  W_TIMER  dodge countdown
- phase_start  out  1  one-clk pulse on entry to DODGE

Behaviour:
- Reset (async, rst_n=0) values:
  - state=TITLE, cursor=0, enemy_hp=ENEMY_HP_MAX, win=0, frames_left=0, phase_start=0.
  - The internal keycode copy is cleared to 16'h0000.
- Make-event detection:
  - Register keycode every clk.
  - `make` is true in cycle N when keycode != registered copy, keycode[15:8] != 8'hF0, and keycode[7:0] != 8'hF0.
  - The key is keycode[7:0]. Break sequences (xxF0, F0xx) never produce events.
  - Re-pressing the same key is detected because the word differs (F01C -> 1C1C).
- Scan codes: ENTER 5A, Z 1A, LEFT 6B, RIGHT 74. All other codes are ignored.
- Latency: outputs change on the clk edge ending the cycle in which `make` or `frame_tick` is seen, so they are visible one cycle later.
- TITLE:
  - ENTER -> MENU.
  - Load enemy_hp=ENEMY_HP_MAX, cursor=0, win=0.
- MENU:
  - LEFT: cursor-1, with 0 wrapping to 3. RIGHT: cursor+1, with 3 wrapping to 0. State is unchanged.
  - Z or ENTER confirms the current cursor value:
    - FIGHT: enemy_hp = max(enemy_hp-DAMAGE, 0), saturating. If the result is 0 -> OVER with win=1; else -> DODGE.
    - ACT or ITEM: -> DODGE, no other effect.
    - MERCY: if enemy_hp <= MERCY_THRESH -> OVER with win=1; else -> DODGE.
  - Every entry to DODGE loads frames_left=DODGE_FRAMES and pulses phase_start for exactly one clk.
- DODGE:
  - Keys are ignored.
  - On frame_tick: if frames_left==0 -> MENU (cursor is kept); else frames_left decrements.
  - hp==0 at any cycle -> OVER with win=0. This has priority over the timer and over a simultaneous frame_tick.
- OVER:
  - ENTER -> TITLE. All other keys are ignored.
  - hp is ignored.
- Simultaneous events:
  - make and frame_tick in the same cycle: both are evaluated against the current state. Only DODGE uses frame_tick and only the other states use make, so they never conflict.
- Reset mid-phase: returns to TITLE immediately and any pending phase_start is suppressed.
- No other state writes frames_left; it holds its value outside DODGE.

Decomposition:
- Shared package holds:
  - state encodings ST_TITLE/ST_DODGE/ST_MENU/ST_OVER (also used by the sprite stages);
  - cursor encodings;
  - scan-code constants KEY_ENTER, KEY_Z, KEY_LEFT, KEY_RIGHT, KEY_BREAK (F0).
- One sub-module is natural: ps2_make_detect (clk, rst_n, keycode -> make, code[7:0]), which holds the registered copy and the break filtering.
- The FSM, counter and HP arithmetic stay in game_state_manager.

Test Plan:
- Reset then keycode 005A -> next cycle state=10, enemy_hp=100, cursor=0. A following F05A (break) causes no change.
- In MENU, keycode sequence 0074, 74F0, F074, 7474 (two RIGHT presses) -> cursor=2. Then 006B, 6BF0, F06B, 6B6B, 006B (three LEFT presses) -> cursor=3 (wrap through 0).
- FIGHT confirm (001A) five times, each followed by a DODGE run to completion:
  - enemy_hp goes 80, 60, 40, 20.
  - The fifth confirm -> state=11, win=1, enemy_hp=0, and no phase_start pulse.
- Enter DODGE, drive 300 frame_ticks:
  - frames_left reaches 0 with state still 01.
  - The 301st tick -> state=10.
  - phase_start was high for exactly one cycle at entry.
- In DODGE, drive hp=0 in the same cycle as a frame_tick with frames_left=0 -> state=11, win=0. Then ENTER -> state=00.
- MERCY with enemy_hp=40 -> DODGE. MERCY with enemy_hp=20 -> OVER, win=1. Assert rst_n=0 mid-DODGE -> state=00, frames_left=0, asynchronously.
